// File: rtl/data_memory_responder.sv
// data_memory_responder
//   Memory-side responder for the pipeline's memory-stage port. Serves
//   word-aligned reads (combinational) and full-word writes (rising edge)
//   from a data RAM plus a small MMIO region holding a free-running cycle
//   timer and a TOHOST halt register.
//
//   Optional feature macro: DMEM_ACCESS_CHECK_EN
//     defined   -> o_AccessError_1 latches unmapped writes and unmapped
//                  reads whose address changed since the previous cycle.
//     undefined -> o_AccessError_1 is tied low.
module data_memory_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic        i_Clk_1,
  input  logic        i_Reset_1,
  input  logic [31:0] i_MemoryAddr_32,
  input  logic [31:0] i_MemoryStoreData_32,
  input  logic        i_MemoryWriteEnable_1,
  output logic [31:0] o_MemoryLoadData_32,
  output logic [31:0] o_CycleCount_32,
  output logic [31:0] o_ToHost_32,
  output logic        o_Halt_1,
  output logic        o_AccessError_1
);

  localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] TOHOST_ADDR = MMIO_BASE + 32'd4;

  logic [31:0]      r_mem [DEPTH_WORDS];
  logic [31:0]      r_cycle_count;
  logic [31:0]      r_to_host;
  logic             r_halt;

  logic             w_ram_hit;
  logic             w_timer_hit;
  logic             w_tohost_hit;
  logic [IDX_W-1:0] w_ram_index;
  logic             w_write_ok;
  logic             w_unused_byte_offset;

  // Address decode: RAM is a power-of-two window aligned to its own size,
  // so a hit is a match of the address bits above the word index.
  assign w_ram_hit    = (i_MemoryAddr_32[31:IDX_W+2] == RAM_BASE[31:IDX_W+2]);
  assign w_ram_index  = i_MemoryAddr_32[IDX_W+1:2];
  assign w_timer_hit  = !w_ram_hit && (i_MemoryAddr_32[31:2] == MMIO_BASE[31:2]);
  assign w_tohost_hit = !w_ram_hit && (i_MemoryAddr_32[31:2] == TOHOST_ADDR[31:2]);
  assign w_write_ok   = i_MemoryWriteEnable_1 && !r_halt;

  // Byte offset within the word is deliberately ignored.
  assign w_unused_byte_offset = ^i_MemoryAddr_32[1:0];

  // Combinational read mux; unmapped addresses read as zero.
  always_comb begin
    // NOTE: default assignment first so every path drives the output and no latch is inferred.
    o_MemoryLoadData_32 = 32'h0;
    if (w_ram_hit) begin
      o_MemoryLoadData_32 = r_mem[w_ram_index];
    end else if (w_timer_hit) begin
      o_MemoryLoadData_32 = r_cycle_count;
    end else if (w_tohost_hit) begin
      o_MemoryLoadData_32 = r_to_host;
    end
  end

  // RAM write port. Reset is folded into the enable so a store presented
  // while reset is asserted never lands, even though the array is not reset.
  always_ff @(posedge i_Clk_1) begin
    // NOTE: the RAM array has no reset; clearing it would turn the block RAM into thousands of flops.
    if (w_write_ok && w_ram_hit && !i_Reset_1) begin
      r_mem[w_ram_index] <= i_MemoryStoreData_32;
    end
  end

  // Timer, TOHOST register and sticky halt flag.
  always_ff @(posedge i_Clk_1 or posedge i_Reset_1) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (i_Reset_1) begin
      r_cycle_count <= 32'h0;
      r_to_host     <= 32'h0;
      r_halt        <= 1'b0;
    end else if (!r_halt) begin
      if (w_write_ok && w_timer_hit) begin
        r_cycle_count <= i_MemoryStoreData_32;
      end else begin
        r_cycle_count <= r_cycle_count + 32'd1;
      end
      if (w_write_ok && w_tohost_hit) begin
        r_to_host <= i_MemoryStoreData_32;
        if (i_MemoryStoreData_32[0]) begin
          r_halt <= 1'b1;
        end
      end
    end
  end

`ifdef DMEM_ACCESS_CHECK_EN
  logic        r_access_error;
  logic [31:0] r_last_addr;
  logic        w_unmapped;
  logic        w_read_valid;

  assign w_unmapped   = !w_ram_hit && !w_timer_hit && !w_tohost_hit;
  // A held read address is one access, not a new one each cycle.
  assign w_read_valid = !i_MemoryWriteEnable_1 && (i_MemoryAddr_32 != r_last_addr);

  // Sticky unmapped-access flag plus the last-address qualifier register.
  always_ff @(posedge i_Clk_1 or posedge i_Reset_1) begin
    if (i_Reset_1) begin
      r_access_error <= 1'b0;
      r_last_addr    <= 32'h0;
    end else begin
      r_last_addr <= i_MemoryAddr_32;
      if (w_unmapped && (w_write_ok || w_read_valid)) begin
        r_access_error <= 1'b1;
      end
    end
  end

  assign o_AccessError_1 = r_access_error;
`else
  assign o_AccessError_1 = 1'b0;
`endif

  assign o_CycleCount_32 = r_cycle_count;
  assign o_ToHost_32     = r_to_host;
  assign o_Halt_1        = r_halt;

endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder
//   Directed test of data_memory_responder. A behavioural model (sparse
//   word map, integer timer, plain flags) is compared against every DUT
//   output on each falling edge; hand-computed literals pin the model.
module tb_data_memory_responder;

  localparam int unsigned DEPTH_WORDS = 4096;
  localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
  localparam logic [31:0] MMIO_BASE   = 32'h8000_0000;
`ifdef DMEM_ACCESS_CHECK_EN
  localparam logic [31:0] ERR_ON     = 32'd1;
`else
  localparam logic [31:0] ERR_ON     = 32'd0;
`endif

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] data = 32'h0;
  logic        we   = 1'b0;

  logic [31:0] load_data;
  logic [31:0] cycle_count;
  logic [31:0] to_host;
  logic        halt;
  logic        access_error;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  logic [31:0] m_mem [int unsigned];
  logic [31:0] m_timer  = 32'h0;
  logic [31:0] m_tohost = 32'h0;
  logic        m_halt   = 1'b0;
  logic        m_err    = 1'b0;
  logic [31:0] m_last   = 32'h0;

  logic [31:0] frozen_timer;

  data_memory_responder #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .RAM_BASE   (RAM_BASE),
    .MMIO_BASE  (MMIO_BASE)
  ) dut (
    .i_Clk_1              (clk),
    .i_Reset_1            (rst),
    .i_MemoryAddr_32      (addr),
    .i_MemoryStoreData_32 (data),
    .i_MemoryWriteEnable_1(we),
    .o_MemoryLoadData_32  (load_data),
    .o_CycleCount_32      (cycle_count),
    .o_ToHost_32          (to_host),
    .o_Halt_1             (halt),
    .o_AccessError_1      (access_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // 0 = RAM, 1 = TIMER, 2 = TOHOST, 3 = unmapped
  function automatic int region(input logic [31:0] a);
    longint unsigned lo = longint'(RAM_BASE);
    longint unsigned hi = lo + 4 * longint'(DEPTH_WORDS);
    if (longint'(a) >= lo && longint'(a) < hi) return 0;
    if ((a & 32'hFFFF_FFFC) == MMIO_BASE) return 1;
    if ((a & 32'hFFFF_FFFC) == MMIO_BASE + 32'd4) return 2;
    return 3;
  endfunction

  function automatic int unsigned word_of(input logic [31:0] a);
    return (a - RAM_BASE) >> 2;
  endfunction

  // One clock edge (or reset assertion) of the model.
  task automatic model_step();
    int          r;
    logic        was_halted;
    logic        timer_loaded;
    if (rst) begin
      m_timer  = 32'h0;
      m_tohost = 32'h0;
      m_halt   = 1'b0;
      m_err    = 1'b0;
      m_last   = 32'h0;
    end else begin
      r            = region(addr);
      was_halted   = m_halt;
      timer_loaded = 1'b0;
      if (!was_halted && we) begin
        case (r)
          0: m_mem[word_of(addr)] = data;
          1: begin m_timer = data; timer_loaded = 1'b1; end
          2: begin m_tohost = data; if (data[0]) m_halt = 1'b1; end
          default: if (ERR_ON[0]) m_err = 1'b1;
        endcase
      end
      if (!was_halted && !timer_loaded) m_timer = m_timer + 32'd1;
      if (ERR_ON[0] && !we && r == 3 && addr != m_last) m_err = 1'b1;
      m_last = addr;
    end
  endtask

  always @(posedge clk or posedge rst) model_step();

  // Compare every DUT output with the model on each falling edge.
  task automatic compare_outputs();
    int          r;
    logic [31:0] exp_load;
    logic        known;
    r        = region(addr);
    known    = 1'b1;
    exp_load = 32'h0;
    case (r)
      0: if (m_mem.exists(word_of(addr))) exp_load = m_mem[word_of(addr)];
         else known = 1'b0;
      1: exp_load = m_timer;
      2: exp_load = m_tohost;
      default: exp_load = 32'h0;
    endcase
    if (known) check("model_load", load_data, exp_load);
    check("model_timer", cycle_count, m_timer);
    check("model_tohost", to_host, m_tohost);
    check("model_halt", {31'b0, halt}, {31'b0, m_halt});
    check("model_err", {31'b0, access_error}, {31'b0, m_err});
  endtask

  always @(negedge clk) compare_outputs();

  task automatic set_in(input logic [31:0] a, input logic [31:0] d, input logic w);
    addr = a;
    data = d;
    we   = w;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Idle ten cycles after reset release
    repeat (10) @(posedge clk);
    #1;
    check("idle_timer_10", cycle_count, 32'd10);
    check("idle_halt_0", {31'b0, halt}, 32'd0);
    check("idle_tohost_0", to_host, 32'd0);

    // Seed a few RAM words
    set_in(32'h0000_0000, 32'hC0FF_EE00, 1'b1); tick();
    set_in(32'h0000_0010, 32'h1111_1111, 1'b1); tick();
    set_in(32'h0000_0020, 32'h0BAD_F00D, 1'b1); tick();
    set_in(32'h0000_0040, 32'h4040_4040, 1'b1); tick();

    // Write-then-read: old value same cycle, new value after the edge
    set_in(32'h0000_0010, 32'hDEAD_BEEF, 1'b1); #1;
    check("same_cycle_old", load_data, 32'h1111_1111);
    tick();
    set_in(32'h0000_0010, 32'h0, 1'b0); #1;
    check("readback", load_data, 32'hDEAD_BEEF);
    set_in(32'h0000_0013, 32'h0, 1'b0); #1;
    check("low_bits_ignored", load_data, 32'hDEAD_BEEF);

    // Timer load and wrap
    set_in(MMIO_BASE, 32'hFFFF_FFFE, 1'b1); tick();
    set_in(MMIO_BASE, 32'h0, 1'b0); #1;
    check("timer_load", load_data, 32'hFFFF_FFFE);
    tick();
    check("timer_max", cycle_count, 32'hFFFF_FFFF);
    tick();
    check("timer_wrap", load_data, 32'h0);

    // Last RAM word
    set_in(32'h0000_3FFC, 32'hA5A5_5A5A, 1'b1); tick();
    set_in(32'h0000_3FFC, 32'h0, 1'b0); #1;
    check("ram_top_word", load_data, 32'hA5A5_5A5A);

    // Unmapped write: dropped, flagged only with the access check built in
    set_in(32'h4000_0000, 32'h5555_5555, 1'b1); #1;
    check("unmapped_read_zero", load_data, 32'h0);
    check("err_before_edge", {31'b0, access_error}, 32'd0);
    tick();
    set_in(32'h0000_0000, 32'h0, 1'b0); #1;
    check("unmapped_write_err", {31'b0, access_error}, ERR_ON);
    check("unmapped_write_dropped", load_data, 32'hC0FF_EE00);
    set_in(32'h0000_4000, 32'h0, 1'b0); #1;
    check("past_ram_end_zero", load_data, 32'h0);
    tick();

    // TOHOST with bit 0 clear: register updates, no halt
    set_in(MMIO_BASE + 32'd4, 32'h0000_0002, 1'b1); tick();
    set_in(MMIO_BASE + 32'd4, 32'h0, 1'b0); #1;
    check("tohost_even", to_host, 32'h2);
    check("tohost_even_read", load_data, 32'h2);
    check("tohost_even_no_halt", {31'b0, halt}, 32'd0);

    // TOHOST with bit 0 set: halt, then writes ignored and timer frozen
    set_in(MMIO_BASE + 32'd4, 32'h0000_0003, 1'b1); tick();
    set_in(32'h0000_0020, 32'h1234_5678, 1'b1); #1;
    check("halt_set", {31'b0, halt}, 32'd1);
    check("halt_tohost", to_host, 32'h3);
    frozen_timer = cycle_count;
    tick();
    set_in(MMIO_BASE, 32'h0000_0055, 1'b1); tick();
    set_in(MMIO_BASE + 32'd4, 32'h0, 1'b1); tick();
    set_in(32'h0000_0020, 32'h0, 1'b0); #1;
    check("halt_ram_kept", load_data, 32'h0BAD_F00D);
    check("halt_timer_frozen", cycle_count, frozen_timer);
    check("halt_tohost_kept", to_host, 32'h3);

    // Asynchronous reset in the middle of a write while halted
    set_in(32'h0000_0040, 32'h7777_7777, 1'b1); #1;
    rst = 1'b1; #1;
    check("rst_timer", cycle_count, 32'h0);
    check("rst_tohost", to_host, 32'h0);
    check("rst_halt", {31'b0, halt}, 32'd0);
    check("rst_err", {31'b0, access_error}, 32'd0);
    tick();
    set_in(32'h0000_0040, 32'h0, 1'b0);
    rst = 1'b0; #1;
    check("rst_ram_kept", load_data, 32'h4040_4040);
    set_in(32'h0000_0010, 32'h0, 1'b0); #1;
    check("rst_ram_kept2", load_data, 32'hDEAD_BEEF);
    tick();
    check("first_edge_timer", cycle_count, 32'd1);

    // Write in flight while reset spans the edge, halt clear
    set_in(32'h0000_0040, 32'h9999_9999, 1'b1); #1;
    rst = 1'b1;
    tick();
    set_in(32'h0000_0040, 32'h0, 1'b0);
    rst = 1'b0; #1;
    check("inflight_write_discarded", load_data, 32'h4040_4040);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
